// File: rtl/spi_rx_slave_fifo.sv
// SPI slave receiver with oversampled inputs, all four SPI modes, and a first-word-fall-through RX FIFO.
// Each received word carries a first-of-frame flag, and MISO echoes the most recently completed word.
module spi_rx_slave_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int CPOL       = 0,
  parameter int CPHA       = 0,
  parameter int MSB_FIRST  = 1
) (
  input  logic                          CLOCK_50,
  input  logic                          reset,
  input  logic                          SCK,
  input  logic                          MOSI,
  input  logic                          SSEL,
  output logic                          MISO,
  output logic                          miso_oe,
  output logic [DATA_W-1:0]             rx_data,
  output logic                          rx_first,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          frame_start,
  output logic                          frame_end,
  output logic                          overflow,
  input  logic                          ovf_clr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam int FIRST_IDX = (MSB_FIRST != 0) ? DATA_W - 1 : 0;
  localparam bit SAMPLE_RISE = ((CPOL != 0) == (CPHA != 0));

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, ACTIVE} state_t;

  logic [2:0] sck_sync_q, ssel_sync_q;
  logic [1:0] mosi_sync_q;
  state_t     state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] last_word_q, last_word_d;
  logic first_q, first_d;
  logic push_q, push_d;
  logic push_first_q, push_first_d;
  logic miso_q, miso_d;
  logic sck_rise, sck_fall, ssel_rise, ssel_fall, sample_edge, shift_edge;
  logic [CNT_W-1:0] tx_idx;

  logic [DATA_W:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             full, pop, do_push;
  logic [DATA_W:0]  head;

  // Stage 2 vs stage 3 gives the edges; SSEL stages reset low so a frame already in progress is not mistaken for idle.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sck_sync_q  <= '0;
      ssel_sync_q <= '0;
      mosi_sync_q <= '0;
    end else begin
      sck_sync_q  <= {sck_sync_q[1:0], SCK};
      ssel_sync_q <= {ssel_sync_q[1:0], SSEL};
      mosi_sync_q <= {mosi_sync_q[0], MOSI};
    end
  end

  assign sck_rise    = sck_sync_q[1] & ~sck_sync_q[2];
  assign sck_fall    = ~sck_sync_q[1] & sck_sync_q[2];
  assign ssel_rise   = ssel_sync_q[1] & ~ssel_sync_q[2];
  assign ssel_fall   = ~ssel_sync_q[1] & ssel_sync_q[2];
  assign sample_edge = SAMPLE_RISE ? sck_rise : sck_fall;
  assign shift_edge  = SAMPLE_RISE ? sck_fall : sck_rise;
  assign tx_idx      = (MSB_FIRST != 0) ? LAST_BIT - bit_cnt_q : bit_cnt_q;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q      <= WAIT_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      last_word_q  <= '0;
      first_q      <= 1'b0;
      push_q       <= 1'b0;
      push_first_q <= 1'b0;
      miso_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      last_word_q  <= last_word_d;
      first_q      <= first_d;
      push_q       <= push_d;
      push_first_q <= push_first_d;
      miso_q       <= miso_d;
    end
  end

  // MISO bit index follows bit_cnt, so the shift edge right after a completed word starts the new echo word.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    last_word_d  = last_word_q;
    first_d      = first_q;
    push_d       = 1'b0;
    push_first_d = push_first_q;
    miso_d       = miso_q;
    frame_start  = 1'b0;
    frame_end    = 1'b0;
    case (state_q)
      WAIT_IDLE: begin
        if (ssel_sync_q[1]) state_d = IDLE;
      end
      IDLE: begin
        if (ssel_fall) begin
          state_d     = ACTIVE;
          frame_start = 1'b1;
          bit_cnt_d   = '0;
          first_d     = 1'b1;
          miso_d      = (CPHA == 0) ? last_word_q[FIRST_IDX] : 1'b0;
        end
      end
      ACTIVE: begin
        if (ssel_rise) begin
          state_d   = IDLE;
          frame_end = 1'b1;
          bit_cnt_d = '0;
        end else if (sample_edge) begin
          if (MSB_FIRST != 0) shift_d = {shift_q[DATA_W-2:0], mosi_sync_q[1]};
          else                shift_d = {mosi_sync_q[1], shift_q[DATA_W-1:1]};
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d    = '0;
            push_d       = 1'b1;
            last_word_d  = shift_d;
            push_first_d = first_q;
            first_d      = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (shift_edge) begin
          miso_d = last_word_q[tx_idx];
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  assign miso_oe = (state_q == ACTIVE);
  assign MISO    = miso_oe & miso_q;

  assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
  assign rx_valid = (count_q != '0);
  assign pop     = rx_valid & rx_ready;
  assign do_push = push_q & (~full | pop);
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({do_push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    overflow_d = overflow_q;
    if (ovf_clr) overflow_d = 1'b0;
    if (push_q && full && !pop) overflow_d = 1'b1;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (do_push && !reset) mem_q[wr_ptr_q] <= {push_first_q, last_word_q};
  end

  assign rx_data    = rx_valid ? head[DATA_W-1:0] : '0;
  assign rx_first   = rx_valid & head[DATA_W];
  assign overflow   = overflow_q;
  assign fifo_level = count_q;

endmodule

// File: tb/tb_spi_rx_slave_fifo.sv
// Directed bench: u0 is mode 0 with a 4-deep FIFO, u1 is mode 3 with a 16-deep FIFO.
// Expected words, flags, levels and MISO echoes are hand-derived constants.
`timescale 1ns/1ps
module tb_spi_rx_slave_fifo;

  localparam int HALF = 1000;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic sck0 = 1'b0, mosi0 = 1'b0, ssel0 = 1'b1;
  logic miso0, misoOe0, rxFirst0, rxValid0, frameStart0, frameEnd0, overflow0;
  logic rxReady0 = 1'b0, ovfClr0 = 1'b0;
  logic [7:0] rxData0;
  logic [2:0] fifoLevel0;

  logic sck1 = 1'b1, mosi1 = 1'b0, ssel1 = 1'b1;
  logic miso1, misoOe1, rxFirst1, rxValid1, frameStart1, frameEnd1, overflow1;
  logic rxReady1 = 1'b0, ovfClr1 = 1'b0;
  logic [7:0] rxData1;
  logic [4:0] fifoLevel1;

  int nCompared = 0;
  int nMismatched = 0;
  int fsCount0 = 0, feCount0 = 0;

  always #10 clk = ~clk;

  spi_rx_slave_fifo #(.DATA_W(8), .FIFO_DEPTH(4), .CPOL(0), .CPHA(0), .MSB_FIRST(1)) u0 (
    .CLOCK_50(clk), .reset(reset), .SCK(sck0), .MOSI(mosi0), .SSEL(ssel0),
    .MISO(miso0), .miso_oe(misoOe0), .rx_data(rxData0), .rx_first(rxFirst0),
    .rx_valid(rxValid0), .rx_ready(rxReady0), .frame_start(frameStart0),
    .frame_end(frameEnd0), .overflow(overflow0), .ovf_clr(ovfClr0), .fifo_level(fifoLevel0));

  spi_rx_slave_fifo #(.DATA_W(8), .FIFO_DEPTH(16), .CPOL(1), .CPHA(1), .MSB_FIRST(1)) u1 (
    .CLOCK_50(clk), .reset(reset), .SCK(sck1), .MOSI(mosi1), .SSEL(ssel1),
    .MISO(miso1), .miso_oe(misoOe1), .rx_data(rxData1), .rx_first(rxFirst1),
    .rx_valid(rxValid1), .rx_ready(rxReady1), .frame_start(frameStart1),
    .frame_end(frameEnd1), .overflow(overflow1), .ovf_clr(ovfClr1), .fifo_level(fifoLevel1));

  always @(negedge clk) begin
    if (frameStart0) fsCount0++;
    if (frameEnd0)   feCount0++;
  end

  task automatic spiSelect(input int b);
    if (b == 0) ssel0 = 1'b0; else ssel1 = 1'b0;
    #HALF;
  endtask

  task automatic spiDeselect(input int b);
    #HALF;
    if (b == 0) ssel0 = 1'b1; else ssel1 = 1'b1;
    #HALF;
    #200;
  endtask

  // Sends the top n bits of data MSB first; got collects MISO as seen just before each sample edge.
  task automatic spiBits(input int b, input logic [7:0] data, input int n, output logic [7:0] got);
    logic bitV;
    got = '0;
    for (int i = 0; i < n; i++) begin
      bitV = data[7-i];
      if (b == 0) begin
        mosi0 = bitV;
        #HALF;
        got = {got[6:0], miso0};
        sck0 = 1'b1;
        #HALF;
        sck0 = 1'b0;
      end else begin
        sck1 = 1'b0;
        mosi1 = bitV;
        #HALF;
        got = {got[6:0], miso1};
        sck1 = 1'b1;
        #HALF;
      end
    end
  endtask

  task automatic popOne(input int b);
    if (b == 0) rxReady0 = 1'b1; else rxReady1 = 1'b1;
    #20;
    rxReady0 = 1'b0;
    rxReady1 = 1'b0;
    #20;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #60;
    nCompared++; if (rxValid0 !== 1'b0) begin nMismatched++; $display("FAIL reset_valid0: got %b want 0", rxValid0); end
    nCompared++; if (fifoLevel0 !== 3'd0) begin nMismatched++; $display("FAIL reset_level0: got %0d want 0", fifoLevel0); end
    nCompared++; if (overflow0 !== 1'b0) begin nMismatched++; $display("FAIL reset_ovf0: got %b want 0", overflow0); end
    nCompared++; if ({misoOe0, miso0} !== 2'b00) begin nMismatched++; $display("FAIL reset_miso0: got %b want 00", {misoOe0, miso0}); end
    nCompared++; if ({rxValid1, misoOe1, miso1} !== 3'b000) begin nMismatched++; $display("FAIL reset_u1: got %b want 000", {rxValid1, misoOe1, miso1}); end
    reset = 1'b0;
    #200;
  endtask

  task automatic test_mode0();
    logic [7:0] g [3];
    logic [7:0] expD [3];
    logic [7:0] expMiso [3];
    logic       expF [3];
    int fs, fe;
    expD = '{8'hAA, 8'h55, 8'h00};
    expMiso = '{8'h00, 8'hAA, 8'h55};
    expF = '{1'b1, 1'b0, 1'b0};
    fs = fsCount0; fe = feCount0;
    spiSelect(0);
    nCompared++; if (misoOe0 !== 1'b1) begin nMismatched++; $display("FAIL m0_oe_active: got %b want 1", misoOe0); end
    for (int i = 0; i < 3; i++) spiBits(0, expD[i], 8, g[i]);
    spiDeselect(0);
    nCompared++; if (misoOe0 !== 1'b0) begin nMismatched++; $display("FAIL m0_oe_idle: got %b want 0", misoOe0); end
    nCompared++; if (fifoLevel0 !== 3'd3) begin nMismatched++; $display("FAIL m0_level: got %0d want 3", fifoLevel0); end
    nCompared++; if (fsCount0 - fs !== 1) begin nMismatched++; $display("FAIL m0_frame_start: got %0d want 1", fsCount0 - fs); end
    nCompared++; if (feCount0 - fe !== 1) begin nMismatched++; $display("FAIL m0_frame_end: got %0d want 1", feCount0 - fe); end
    for (int i = 0; i < 3; i++) begin
      nCompared++; if (g[i] !== expMiso[i]) begin nMismatched++; $display("FAIL m0_miso[%0d]: got %h want %h", i, g[i], expMiso[i]); end
      nCompared++; if ({rxValid0, rxFirst0, rxData0} !== {1'b1, expF[i], expD[i]}) begin
        nMismatched++; $display("FAIL m0_pop[%0d]: got v%b f%b %h want v1 f%b %h", i, rxValid0, rxFirst0, rxData0, expF[i], expD[i]);
      end
      popOne(0);
    end
    nCompared++; if (rxValid0 !== 1'b0) begin nMismatched++; $display("FAIL m0_empty: got %b want 0", rxValid0); end
  endtask

  task automatic test_mode3();
    logic [7:0] g [3];
    logic [7:0] g2;
    logic [7:0] expD [3];
    logic [7:0] expMiso [3];
    expD = '{8'h00, 8'h55, 8'hAA};
    expMiso = '{8'h00, 8'h00, 8'h55};
    spiSelect(1);
    for (int i = 0; i < 3; i++) spiBits(1, expD[i], 8, g[i]);
    spiDeselect(1);
    nCompared++; if (fifoLevel1 !== 5'd3) begin nMismatched++; $display("FAIL m3_level: got %0d want 3", fifoLevel1); end
    for (int i = 0; i < 3; i++) begin
      nCompared++; if (g[i] !== expMiso[i]) begin nMismatched++; $display("FAIL m3_miso[%0d]: got %h want %h", i, g[i], expMiso[i]); end
      nCompared++; if ({rxValid1, rxFirst1, rxData1} !== {1'b1, (i == 0), expD[i]}) begin
        nMismatched++; $display("FAIL m3_pop[%0d]: got v%b f%b %h want v1 f%b %h", i, rxValid1, rxFirst1, rxData1, (i == 0), expD[i]);
      end
      popOne(1);
    end
    spiSelect(1);
    spiBits(1, 8'h12, 8, g2);
    spiDeselect(1);
    nCompared++; if (g2 !== 8'hAA) begin nMismatched++; $display("FAIL m3_miso_f2: got %h want aa", g2); end
    nCompared++; if ({rxValid1, rxFirst1, rxData1, fifoLevel1} !== {1'b1, 1'b1, 8'h12, 5'd1}) begin
      nMismatched++; $display("FAIL m3_frame2: got v%b f%b %h lvl%0d want v1 f1 12 lvl1", rxValid1, rxFirst1, rxData1, fifoLevel1);
    end
    popOne(1);
  endtask

  task automatic test_partial();
    logic [7:0] g;
    spiSelect(0);
    spiBits(0, 8'hA5, 8, g);
    spiBits(0, 8'h30, 4, g);
    spiDeselect(0);
    nCompared++; if (fifoLevel0 !== 3'd1) begin nMismatched++; $display("FAIL part_level1: got %0d want 1", fifoLevel0); end
    spiSelect(0);
    spiBits(0, 8'h5A, 8, g);
    spiDeselect(0);
    nCompared++; if (fifoLevel0 !== 3'd2) begin nMismatched++; $display("FAIL part_level2: got %0d want 2", fifoLevel0); end
    nCompared++; if ({rxFirst0, rxData0} !== {1'b1, 8'hA5}) begin nMismatched++; $display("FAIL part_pop0: got f%b %h want f1 a5", rxFirst0, rxData0); end
    popOne(0);
    nCompared++; if ({rxFirst0, rxData0} !== {1'b1, 8'h5A}) begin nMismatched++; $display("FAIL part_pop1: got f%b %h want f1 5a", rxFirst0, rxData0); end
    popOne(0);
  endtask

  task automatic test_overflow();
    logic [7:0] g;
    spiSelect(0);
    for (int i = 1; i <= 5; i++) spiBits(0, 8'(i), 8, g);
    spiDeselect(0);
    nCompared++; if (fifoLevel0 !== 3'd4) begin nMismatched++; $display("FAIL ovf_level: got %0d want 4", fifoLevel0); end
    nCompared++; if (overflow0 !== 1'b1) begin nMismatched++; $display("FAIL ovf_set: got %b want 1", overflow0); end
    for (int i = 1; i <= 4; i++) begin
      nCompared++; if ({rxValid0, rxFirst0, rxData0} !== {1'b1, (i == 1), 8'(i)}) begin
        nMismatched++; $display("FAIL ovf_pop[%0d]: got v%b f%b %h want v1 f%b %h", i, rxValid0, rxFirst0, rxData0, (i == 1), 8'(i));
      end
      popOne(0);
    end
    nCompared++; if ({rxValid0, overflow0} !== 2'b01) begin nMismatched++; $display("FAIL ovf_sticky: got %b want 01", {rxValid0, overflow0}); end
    ovfClr0 = 1'b1;
    #20;
    ovfClr0 = 1'b0;
    #20;
    nCompared++; if (overflow0 !== 1'b0) begin nMismatched++; $display("FAIL ovf_clr: got %b want 0", overflow0); end
  endtask

  task automatic test_full_pop();
    logic [7:0] g;
    logic [7:0] expD [4];
    logic       expF [4];
    expD = '{8'h02, 8'h03, 8'h04, 8'h06};
    expF = '{1'b0, 1'b0, 1'b0, 1'b1};
    spiSelect(0);
    for (int i = 1; i <= 4; i++) spiBits(0, 8'(i), 8, g);
    spiDeselect(0);
    nCompared++; if ({fifoLevel0, overflow0} !== {3'd4, 1'b0}) begin nMismatched++; $display("FAIL full_pre: got lvl%0d ovf%b want lvl4 ovf0", fifoLevel0, overflow0); end
    spiSelect(0);
    spiBits(0, 8'h06, 7, g);
    // Last bit: the push lands on the 4th clock edge after the sample edge, so ready covers exactly that edge.
    mosi0 = 1'b0;
    #HALF;
    sck0 = 1'b1;
    #60;
    rxReady0 = 1'b1;
    #20;
    rxReady0 = 1'b0;
    #(HALF - 80);
    sck0 = 1'b0;
    spiDeselect(0);
    nCompared++; if ({fifoLevel0, overflow0} !== {3'd4, 1'b0}) begin nMismatched++; $display("FAIL full_post: got lvl%0d ovf%b want lvl4 ovf0", fifoLevel0, overflow0); end
    for (int i = 0; i < 4; i++) begin
      nCompared++; if ({rxValid0, rxFirst0, rxData0} !== {1'b1, expF[i], expD[i]}) begin
        nMismatched++; $display("FAIL full_pop[%0d]: got v%b f%b %h want v1 f%b %h", i, rxValid0, rxFirst0, rxData0, expF[i], expD[i]);
      end
      popOne(0);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] g0, g1;
    spiSelect(0);
    spiBits(0, 8'hF0, 4, g0);
    reset = 1'b1;
    #60;
    reset = 1'b0;
    spiBits(0, 8'h0F, 4, g0);
    spiBits(0, 8'hC3, 8, g0);
    #200;
    nCompared++; if ({rxValid0, fifoLevel0, overflow0} !== {1'b0, 3'd0, 1'b0}) begin
      nMismatched++; $display("FAIL rst_mid_fifo: got v%b lvl%0d ovf%b want v0 lvl0 ovf0", rxValid0, fifoLevel0, overflow0);
    end
    nCompared++; if ({misoOe0, miso0} !== 2'b00) begin nMismatched++; $display("FAIL rst_mid_oe: got %b want 00", {misoOe0, miso0}); end
    spiDeselect(0);
    spiSelect(0);
    spiBits(0, 8'hAA, 8, g0);
    spiBits(0, 8'h55, 8, g1);
    spiDeselect(0);
    nCompared++; if (fifoLevel0 !== 3'd2) begin nMismatched++; $display("FAIL rst_mid_level: got %0d want 2", fifoLevel0); end
    nCompared++; if ({g0, g1} !== {8'h00, 8'hAA}) begin nMismatched++; $display("FAIL rst_mid_miso: got %h %h want 00 aa", g0, g1); end
    nCompared++; if ({rxFirst0, rxData0} !== {1'b1, 8'hAA}) begin nMismatched++; $display("FAIL rst_mid_pop0: got f%b %h want f1 aa", rxFirst0, rxData0); end
    popOne(0);
    nCompared++; if ({rxFirst0, rxData0} !== {1'b0, 8'h55}) begin nMismatched++; $display("FAIL rst_mid_pop1: got f%b %h want f0 55", rxFirst0, rxData0); end
    popOne(0);
  endtask

  initial begin
    #5;
    test_reset();
    test_mode0();
    test_mode3();
    test_partial();
    test_overflow();
    test_full_pop();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #1500000;
    nMismatched++;
    $display("FAIL watchdog: run still going at %0t, limit 1500000 ns", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
